keypad_scanner: RTL and testbench

- Reads a 4x4 matrix keypad, the input-side counterpart of the multiplexed 7-segment display driver. The display side time-multiplexes common lines outward; this block time-multiplexes row lines and samples column lines inward.
- Synchronises and debounces whole-matrix snapshots, then emits one-cycle key events with a 4-bit code.
- The watch top and the setting logic use these events, alongside or in place of the 4-button debounce path.

---
 rtl/keypad_scanner_pkg.sv | 49 ++++
 rtl/keypad_scanner_if.sv | 31 +++
 rtl/keypad_scanner_row_scan.sv | 69 ++++++
 rtl/keypad_scanner.sv | 139 +++++++++++++
 tb/tb_keypad_scanner.sv | 255 +++++++++++++++++++++++++
 5 files changed

// File: rtl/keypad_scanner_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESSED,
    ST_MULTI
  } state_t;

  typedef enum logic [1:0] {
    CL_NONE,
    CL_SINGLE,
    CL_MULTI
  } class_t;

  // Number of pressed keys in a snapshot.
  function automatic logic [4:0] popcount16(input logic [NUM_KEYS-1:0] v);
    logic [4:0] cnt;
    cnt = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      cnt = cnt + 5'(v[i]);
    end
    return cnt;
  endfunction

  // Index of the lowest pressed key; only meaningful when exactly one bit is set.
  function automatic logic [3:0] first_one16(input logic [NUM_KEYS-1:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = NUM_KEYS - 1; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

  // Reduce a snapshot to none / one / several keys.
  function automatic class_t classify(input logic [NUM_KEYS-1:0] v);
    logic [4:0] cnt;
    cnt = popcount16(v);
    if (cnt == 5'd0)      return CL_NONE;
    else if (cnt == 5'd1) return CL_SINGLE;
    else                  return CL_MULTI;
  endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Keypad matrix pins plus the key-event bus towards the watch logic.
interface keypad_scanner_if;
  import keypad_pkg::*;

  logic [NUM_ROWS-1:0] row_out;
  logic [NUM_COLS-1:0] col_in;
  logic                key_valid;
  logic [3:0]          key_code;
  logic                key_held;
  logic                key_multi;

  // Scanner side: drives rows and events, senses columns.
  modport master (
    output row_out,
    output key_valid,
    output key_code,
    output key_held,
    output key_multi,
    input  col_in
  );

  // Keypad / consumer side.
  modport slave (
    input  row_out,
    input  key_valid,
    input  key_code,
    input  key_held,
    input  key_multi,
    output col_in
  );
endinterface

// File: rtl/keypad_scanner_row_scan.sv
// Row strobing, column synchroniser and full-matrix snapshot assembly.
module keypad_row_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV = 6000
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NUM_COLS-1:0] i_col_in,
  output logic [NUM_ROWS-1:0] o_row_out,
  output logic                o_scan_done,
  output logic [NUM_KEYS-1:0] o_snap
);

  localparam int DIV_W = $clog2(SCAN_DIV);

  logic [DIV_W-1:0]    r_div_cnt;
  logic [1:0]          r_row_idx;
  logic [NUM_COLS-1:0] r_col_meta;
  logic [NUM_COLS-1:0] r_col_sync;
  logic [NUM_KEYS-1:0] r_snap;
  logic                r_scan_done;
  logic                w_sample;

  // Sample at the end of each row slot so the lines have settled and crossed the synchroniser.
  assign w_sample = (r_div_cnt == DIV_W'(SCAN_DIV - 1));

  // Two-flop synchroniser for the asynchronous, pulled-up column lines.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col_meta <= '1;
      r_col_sync <= '1;
    end else begin
      r_col_meta <= i_col_in;
      r_col_sync <= r_col_meta;
    end
  end

  // Row slot timer and row index; the index wraps 3 -> 0 naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div_cnt <= '0;
      r_row_idx <= '0;
    end else if (w_sample) begin
      r_div_cnt <= '0;
      r_row_idx <= r_row_idx + 2'd1;
    end else begin
      r_div_cnt <= r_div_cnt + DIV_W'(1);
    end
  end

  // Capture the active row into the snapshot; flag completion after the last row.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_snap      <= '0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= w_sample && (r_row_idx == 2'd3);
      if (w_sample) begin
        r_snap[{r_row_idx, 2'b00} +: NUM_COLS] <= ~r_col_sync;
      end
    end
  end

  assign o_row_out   = ~(4'b0001 << r_row_idx);
  assign o_scan_done = r_scan_done;
  assign o_snap      = r_snap;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: snapshot debounce, classification and key-event FSM.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 6000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  keypad_scanner_if.master  kp
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS);

  logic [NUM_ROWS-1:0] w_row_out;
  logic                w_scan_done;
  logic [NUM_KEYS-1:0] w_snap;
  logic                w_same;
  logic                w_qual;
  class_t              w_class;
  logic [3:0]          w_code;

  logic [NUM_KEYS-1:0] r_prev_snap;
  logic [CNT_W-1:0]    r_stable_cnt;
  state_t              r_state;
  logic                r_key_valid;
  logic [3:0]          r_key_code;
  logic                r_key_held;
  logic                r_key_multi;

  keypad_row_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_row_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_col_in    (kp.col_in),
    .o_row_out   (w_row_out),
    .o_scan_done (w_scan_done),
    .o_snap      (w_snap)
  );

  // Qualification fires only on the scan that makes the run exactly DEBOUNCE_SCANS long.
  assign w_same  = (w_snap == r_prev_snap);
  assign w_qual  = w_scan_done && w_same && (r_stable_cnt == CNT_W'(DEBOUNCE_SCANS - 2));
  assign w_class = classify(w_snap);
  assign w_code  = first_one16(w_snap);

  // Count consecutive identical snapshots, saturating so a long hold never re-qualifies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prev_snap  <= '0;
      r_stable_cnt <= '0;
    end else if (w_scan_done) begin
      if (w_same) begin
        if (r_stable_cnt != CNT_W'(DEBOUNCE_SCANS - 1)) begin
          r_stable_cnt <= r_stable_cnt + CNT_W'(1);
        end
      end else begin
        r_stable_cnt <= '0;
      end
      r_prev_snap <= w_snap;
    end
  end

  // Key-event FSM; leaving MULTI into a single key updates the code silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_key_valid <= 1'b0;
      r_key_code  <= '0;
      r_key_held  <= 1'b0;
      r_key_multi <= 1'b0;
    end else begin
      r_key_valid <= 1'b0;
      if (w_qual) begin
        case (r_state)
          ST_IDLE: begin
            case (w_class)
              CL_SINGLE: begin
                r_state     <= ST_PRESSED;
                r_key_code  <= w_code;
                r_key_valid <= 1'b1;
                r_key_held  <= 1'b1;
              end
              CL_MULTI: begin
                r_state     <= ST_MULTI;
                r_key_multi <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_PRESSED: begin
            case (w_class)
              CL_NONE: begin
                r_state    <= ST_IDLE;
                r_key_held <= 1'b0;
              end
              CL_SINGLE: begin
                if (w_code != r_key_code) begin
                  r_key_code  <= w_code;
                  r_key_valid <= 1'b1;
                end
              end
              CL_MULTI: begin
                r_state     <= ST_MULTI;
                r_key_held  <= 1'b0;
                r_key_multi <= 1'b1;
              end
              default: ;
            endcase
          end
          ST_MULTI: begin
            case (w_class)
              CL_NONE: begin
                r_state     <= ST_IDLE;
                r_key_multi <= 1'b0;
              end
              CL_SINGLE: begin
                r_state     <= ST_PRESSED;
                r_key_code  <= w_code;
                r_key_held  <= 1'b1;
                r_key_multi <= 1'b0;
              end
              default: ;
            endcase
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign kp.row_out   = w_row_out;
  assign kp.key_valid = r_key_valid;
  assign kp.key_code  = r_key_code;
  assign kp.key_held  = r_key_held;
  assign kp.key_multi = r_key_multi;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: a scan-level model of the keypad behaviour plus directed key scenarios.
module tb_keypad_scanner;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 2;
  localparam int SCAN     = 4 * SCAN_DIV;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] keys  = '0;

  keypad_scanner_if kp_if();

  keypad_scanner #(
    .SCAN_DIV       (SCAN_DIV),
    .DEBOUNCE_SCANS (DEB)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .kp    (kp_if.master)
  );

  always #5 clk = ~clk;

  // Physical keypad: a pressed key pulls its column low only while its row is driven low.
  always_comb begin
    logic [3:0] c;
    c = 4'hF;
    for (int r = 0; r < 4; r++) begin
      if (!kp_if.row_out[r]) c = c & ~keys[r*4 +: 4];
    end
    kp_if.col_in = c;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      if (n_bad <= 40) $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_edges = 0;
  logic [3:0]  hist [32];
  logic [15:0] m_last  = '0;
  int          m_run   = 1;
  logic        e_valid = 1'b0, e_held = 1'b0, e_multi = 1'b0;
  logic [3:0]  e_code  = '0;
  logic        p_pend  = 1'b0, p_valid = 1'b0, p_held = 1'b0, p_multi = 1'b0;
  logic [3:0]  p_code  = '0;

  initial begin : model
    int          n;
    int          pc;
    int          idx;
    logic [15:0] snap;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_edges = 0; m_last = '0; m_run = 1; p_pend = 1'b0;
        e_valid = 1'b0; e_held = 1'b0; e_multi = 1'b0; e_code = '0;
      end else begin
        n = m_edges;
        e_valid = 1'b0;
        if (p_pend) begin
          e_valid = p_valid; e_held = p_held; e_multi = p_multi; e_code = p_code;
          p_pend = 1'b0;
        end
        hist[n % 32] = kp_if.col_in;
        if (n % SCAN == SCAN - 1) begin
          // Each row is seen through the column lines as they stood 2 clocks before its sample.
          for (int r = 0; r < 4; r++) snap[r*4 +: 4] = ~hist[(n - 14 + 4*r) % 32];
          if (snap == m_last) m_run++;
          else m_run = 1;
          m_last = snap;
          if (m_run == DEB) begin
            pc = $countones(snap);
            idx = 0;
            for (int i = 15; i >= 0; i--) if (snap[i]) idx = i;
            p_valid = 1'b0; p_held = e_held; p_multi = e_multi; p_code = e_code;
            if (pc == 0) begin
              p_held = 1'b0; p_multi = 1'b0;
            end else if (pc == 1) begin
              if (e_held) begin
                if (idx != int'(e_code)) begin p_valid = 1'b1; p_code = 4'(idx); end
              end else if (e_multi) begin
                p_held = 1'b1; p_multi = 1'b0; p_code = 4'(idx);
              end else begin
                p_valid = 1'b1; p_held = 1'b1; p_code = 4'(idx);
              end
            end else begin
              p_held = 1'b0; p_multi = 1'b1;
            end
            p_pend = 1'b1;
          end
        end
        m_edges = n + 1;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  int         n_pulse   = 0;
  logic [3:0] last_code = '0;
  logic       prev_vld  = 1'b0;

  initial begin : compare
    logic [3:0] er;
    forever begin
      @(negedge clk);
      er = rst_n ? ~(4'b0001 << ((m_edges / SCAN_DIV) % 4)) : 4'b1110;
      check("row_out",   kp_if.row_out,   er);
      check("key_valid", kp_if.key_valid, e_valid);
      check("key_code",  kp_if.key_code,  e_code);
      check("key_held",  kp_if.key_held,  e_held);
      check("key_multi", kp_if.key_multi, e_multi);
      check("held_and_multi", int'(kp_if.key_held & kp_if.key_multi), 0);
      check("valid_back_to_back", int'(kp_if.key_valid & prev_vld), 0);
      prev_vld = kp_if.key_valid;
      if (kp_if.key_valid) begin
        n_pulse++;
        last_code = kp_if.key_code;
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic wait_scans(input int s);
    repeat (s * SCAN) @(negedge clk);
  endtask

  task automatic align_scan();
    int g;
    g = 0;
    while ((m_edges % SCAN) != 0 && g < 64) begin
      @(negedge clk);
      g++;
    end
    if (g >= 64) check("align_timeout", 1, 0);
  endtask

  initial begin : stim
    logic [3:0] rowlit [4];
    int p0;
    rowlit[0] = 4'b1110; rowlit[1] = 4'b1101; rowlit[2] = 4'b1011; rowlit[3] = 4'b0111;

    // Reset and idle
    repeat (3) @(negedge clk);
    check("rst_row", kp_if.row_out, 4'b1110);
    check("rst_valid", kp_if.key_valid, 0);
    check("rst_code", kp_if.key_code, 0);
    rst_n = 1'b1;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i % 4 == 0 && i <= 16) check("idle_row_seq", kp_if.row_out, rowlit[(i / 4) % 4]);
    end
    check("idle_pulses", n_pulse, 0);
    check("idle_held", kp_if.key_held, 0);
    check("idle_multi", kp_if.key_multi, 0);

    // Single key row 2 col 1
    p0 = n_pulse;
    keys = 16'(1 << 9);
    wait_scans(10);
    check("k9_pulses", n_pulse - p0, 1);
    check("k9_code", last_code, 9);
    check("k9_held", kp_if.key_held, 1);
    keys = '0;
    wait_scans(4);
    check("k9_release_held", kp_if.key_held, 0);
    check("k9_release_pulses", n_pulse - p0, 1);

    // Bouncing row 0 col 3: pressed on alternate row-0 samples only
    align_scan();
    p0 = n_pulse;
    for (int s = 0; s < 5; s++) begin
      keys = (s % 2 == 0) ? 16'h0008 : 16'h0000;
      repeat (8) @(negedge clk);
      keys = (s % 2 == 0) ? 16'h0000 : 16'h0008;
      repeat (8) @(negedge clk);
    end
    check("bounce_no_pulse", n_pulse - p0, 0);
    keys = 16'h0008;
    wait_scans(4);
    check("bounce_pulses", n_pulse - p0, 1);
    check("bounce_code", last_code, 3);
    check("bounce_held", kp_if.key_held, 1);
    keys = '0;
    wait_scans(4);

    // Key 5, add key 10, then leave key 10 alone
    p0 = n_pulse;
    keys = 16'(1 << 5);
    wait_scans(4);
    check("k5_pulses", n_pulse - p0, 1);
    check("k5_code", last_code, 5);
    keys = keys | 16'(1 << 10);
    wait_scans(4);
    check("multi_flag", kp_if.key_multi, 1);
    check("multi_held", kp_if.key_held, 0);
    check("multi_code", kp_if.key_code, 5);
    keys = 16'(1 << 10);
    wait_scans(4);
    check("lift_held", kp_if.key_held, 1);
    check("lift_multi", kp_if.key_multi, 0);
    check("lift_code", kp_if.key_code, 10);
    check("lift_no_pulse", n_pulse - p0, 1);
    keys = '0;
    wait_scans(4);
    check("lift_release_held", kp_if.key_held, 0);

    // Rollover 0 -> 15 without a gap
    p0 = n_pulse;
    keys = 16'h0001;
    wait_scans(4);
    check("roll_first_code", last_code, 0);
    check("roll_first_pulses", n_pulse - p0, 1);
    keys = 16'h8000;
    wait_scans(4);
    check("roll_second_code", last_code, 15);
    check("roll_second_pulses", n_pulse - p0, 2);
    check("roll_held", kp_if.key_held, 1);
    keys = '0;
    wait_scans(4);

    // Reset mid-row while key 7 is held
    keys = 16'(1 << 7);
    wait_scans(4);
    check("k7_code", last_code, 7);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_row", kp_if.row_out, 4'b1110);
    check("midrst_held", kp_if.key_held, 0);
    check("midrst_code", kp_if.key_code, 0);
    check("midrst_multi", kp_if.key_multi, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    p0 = n_pulse;
    wait_scans(4);
    check("k7_redetect_pulses", n_pulse - p0, 1);
    check("k7_redetect_code", last_code, 7);
    check("k7_redetect_held", kp_if.key_held, 1);
    keys = '0;
    wait_scans(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
